// File: rtl/mtsp_scs_pkg.sv
// Shared definitions for the SCs writeback path: lane geometry, the result
// record carried through the writeback FIFO, and a lane-masking helper.
package mtsp_scs_pkg;

    localparam int SCS_LANES  = 4;
    localparam int SCS_WORD_W = 32;
    localparam int SCS_TAG_W  = 4;

    // Lane 3 is X, lane 0 is W, matching the {X,Y,Z,W} order of the mask.
    typedef logic [SCS_LANES-1:0][SCS_WORD_W-1:0] scs_data_t;

    typedef struct packed {
        logic [SCS_TAG_W-1:0] tag;
        logic [SCS_LANES-1:0] mask;
        scs_data_t            data;
    } scs_result_t;

    // Zero every lane whose enable bit is clear.
    function automatic scs_data_t scs_mask_lanes(input scs_data_t d,
                                                 input logic [SCS_LANES-1:0] m);
        scs_data_t r;
        for (int l = 0; l < SCS_LANES; l++) begin
            r[l] = m[l] ? d[l] : '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mtsp_scs_wb_fifo.sv
// Result FIFO for the SCs writeback path. Power-of-two depth, pointers carry
// one extra wrap bit so full and empty are distinguishable. The caller must
// only push when not full or when popping in the same cycle.
module mtsp_scs_wb_fifo
    import mtsp_scs_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = scs_result_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int PW = $clog2(DEPTH);

    T            mem_q [DEPTH];
    logic [PW:0] wr_q;
    logic [PW:0] rd_q;
    logic [PW:0] wr_d;
    logic [PW:0] rd_d;
    logic        do_pop;

    assign empty  = (wr_q == rd_q);
    assign full   = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign head   = mem_q[rd_q[PW-1:0]];
    assign do_pop = pop && !empty;

    // Advance pointers on push/pop; wrap is implicit in the power-of-two width.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) wr_d = wr_q + 1'b1;
        if (do_pop) rd_d = rd_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset; the reader gates it with empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mtsp_scs_writeback.sv
// Writeback stage for the SCs primitive: tracks issued instructions through a
// LATENCY-deep tag pipe, captures lane results when each one exits, masks off
// disabled lanes and queues them in order for a ready/valid consumer. Issue is
// credit-throttled so the FIFO can never overflow.
// Optional build macro: MTSP_SCS_WB_BYPASS_EN (present an exiting result
// combinationally when the FIFO is empty, saving one cycle).
module mtsp_scs_writeback
    import mtsp_scs_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  ISSUE_nEN,
    input  logic [TAG_W-1:0]      ISSUE_TAG,
    input  logic [SCS_LANES-1:0]  ISSUE_MASK,
    output logic                  ISSUE_READY,
    input  logic [SCS_WORD_W-1:0] IX,
    input  logic [SCS_WORD_W-1:0] IY,
    input  logic [SCS_WORD_W-1:0] IZ,
    input  logic [SCS_WORD_W-1:0] IW,
    output logic                  O_VALID,
    input  logic                  O_READY,
    output logic [TAG_W-1:0]      O_TAG,
    output logic [SCS_LANES-1:0]  O_MASK,
    output logic [SCS_WORD_W-1:0] O_X,
    output logic [SCS_WORD_W-1:0] O_Y,
    output logic [SCS_WORD_W-1:0] O_Z,
    output logic [SCS_WORD_W-1:0] O_W,
    output logic                  OVERRUN
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [SCS_LANES-1:0] mask;
        scs_data_t            data;
    } wb_entry_t;

    logic [LATENCY-1:0]   pipe_valid_q;
    logic [TAG_W-1:0]     pipe_tag_q  [LATENCY];
    logic [SCS_LANES-1:0] pipe_mask_q [LATENCY];
    logic [CW-1:0]        credit_q;
    logic [CW-1:0]        credit_d;
    logic                 overrun_q;

    logic      issue_accept;
    logic      exit_valid;
    wb_entry_t exit_entry;
    wb_entry_t out_entry;
    wb_entry_t fifo_head;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_full;
    logic      fifo_empty;
    logic      out_valid;
    logic      handshake;

    assign ISSUE_READY  = (credit_q < CW'(DEPTH));
    assign issue_accept = !ISSUE_nEN && ISSUE_READY;
    assign exit_valid   = pipe_valid_q[LATENCY-1];
    assign OVERRUN      = overrun_q;

    // Tag/mask shift pipe that mirrors the primitive's fixed latency.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pipe_valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag_q[i]  <= '0;
                pipe_mask_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= issue_accept;
            pipe_tag_q[0]   <= ISSUE_TAG;
            pipe_mask_q[0]  <= ISSUE_MASK;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_tag_q[i]   <= pipe_tag_q[i-1];
                pipe_mask_q[i]  <= pipe_mask_q[i-1];
            end
        end
    end

    // Build the record for the entry leaving the pipe, with disabled lanes zeroed.
    always_comb begin
        exit_entry      = '0;
        exit_entry.tag  = pipe_tag_q[LATENCY-1];
        exit_entry.mask = pipe_mask_q[LATENCY-1];
        exit_entry.data = scs_mask_lanes({IX, IY, IZ, IW}, pipe_mask_q[LATENCY-1]);
    end

    // Choose what the consumer sees and decide FIFO push/pop.
    always_comb begin
        out_valid = !fifo_empty;
        out_entry = fifo_head;
        fifo_push = exit_valid && (!fifo_full || (O_READY && !fifo_empty));
`ifdef MTSP_SCS_WB_BYPASS_EN
        if (fifo_empty && exit_valid) begin
            out_valid = 1'b1;
            out_entry = exit_entry;
            fifo_push = !O_READY;
        end
`endif
        if (!out_valid) out_entry = '0;
        fifo_pop  = !fifo_empty && O_READY;
        handshake = out_valid && O_READY;
    end

    mtsp_scs_wb_fifo #(
        .DEPTH (DEPTH),
        .T     (wb_entry_t)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (nRST),
        .push      (fifo_push),
        .push_data (exit_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Credits cover everything in flight or buffered; simultaneous issue and drain cancel.
    always_comb begin
        credit_d = credit_q;
        if (issue_accept && !handshake) credit_d = credit_q + 1'b1;
        else if (!issue_accept && handshake) credit_d = credit_q - 1'b1;
    end

    // Credit counter and sticky overrun flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            credit_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            credit_q  <= credit_d;
            overrun_q <= overrun_q || (!ISSUE_nEN && !ISSUE_READY);
        end
    end

    assign O_VALID = out_valid;
    assign O_TAG   = out_entry.tag;
    assign O_MASK  = out_entry.mask;
    assign O_X     = out_entry.data[3];
    assign O_Y     = out_entry.data[2];
    assign O_Z     = out_entry.data[1];
    assign O_W     = out_entry.data[0];

endmodule

// File: tb/tb_mtsp_scs_writeback.sv
// Self-checking bench for mtsp_scs_writeback. A reference model tracks
// credits, overrun and an ordered queue of expected results with the cycle at
// which each should become visible; the DUT is compared against it every cycle.
module tb_mtsp_scs_writeback;

   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;
`ifdef MTSP_SCS_WB_BYPASS_EN
   localparam int OUT_LAT = LATENCY;
`else
   localparam int OUT_LAT = LATENCY + 1;
`endif

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [3:0]       mask;
      logic [31:0]      x, y, z, w;
      int               readyCyc;
   } exp_t;

   typedef struct {
      int          cyc;
      logic [31:0] x, y, z, w;
   } cap_t;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             ISSUE_nEN;
   logic [TAG_W-1:0] ISSUE_TAG;
   logic [3:0]       ISSUE_MASK;
   logic             ISSUE_READY;
   logic [31:0]      IX, IY, IZ, IW;
   logic             O_VALID;
   logic             O_READY;
   logic [TAG_W-1:0] O_TAG;
   logic [3:0]       O_MASK;
   logic [31:0]      O_X, O_Y, O_Z, O_W;
   logic             OVERRUN;

   logic [31:0] issueX, issueY, issueZ, issueW;

   exp_t sb[$];
   cap_t capQ[$];
   int   cyc = 0;
   int   tbCredit = 0;
   bit   tbOverrun = 1'b0;
   bit   started = 1'b0;
   int   compareCount = 0;
   int   mismatchCount = 0;

   mtsp_scs_writeback #(
      .LATENCY (LATENCY),
      .DEPTH   (DEPTH),
      .TAG_W   (TAG_W)
   ) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ISSUE_nEN   (ISSUE_nEN),
      .ISSUE_TAG   (ISSUE_TAG),
      .ISSUE_MASK  (ISSUE_MASK),
      .ISSUE_READY (ISSUE_READY),
      .IX          (IX),
      .IY          (IY),
      .IZ          (IZ),
      .IW          (IW),
      .O_VALID     (O_VALID),
      .O_READY     (O_READY),
      .O_TAG       (O_TAG),
      .O_MASK      (O_MASK),
      .O_X         (O_X),
      .O_Y         (O_Y),
      .O_Z         (O_Z),
      .O_W         (O_W),
      .OVERRUN     (OVERRUN)
   );

   // Free-running clock and cycle counter.
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Count one comparison and report it if it disagrees.
   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compareCount++;
      if (obs !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Drive one cycle of issue inputs starting at the falling edge.
   task automatic applyStimulus(input bit en, input logic [TAG_W-1:0] tag, input logic [3:0] mask,
                                input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] z, input logic [31:0] w);
      @(negedge CLK);
      ISSUE_nEN  = !en;
      ISSUE_TAG  = tag;
      ISSUE_MASK = mask;
      issueX = x; issueY = y; issueZ = z; issueW = w;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);
   endtask

   // Drive primitive results at the expected capture cycle (garbage otherwise),
   // then sample the DUT late in the cycle and step the reference model.
   always @(negedge CLK) begin
      bit   expValid;
      bit   accept;
      bit   hs;
      exp_t e;
      if (capQ.size() > 0 && capQ[0].cyc == cyc) begin
         IX = capQ[0].x; IY = capQ[0].y; IZ = capQ[0].z; IW = capQ[0].w;
         void'(capQ.pop_front());
      end else begin
         IX = 32'hDEAD_0000 + 32'(cyc);
         IY = 32'hBEEF_0000 + 32'(cyc);
         IZ = 32'hCAFE_0000 + 32'(cyc);
         IW = 32'hF00D_0000 + 32'(cyc);
      end
      #2;
      if (started) begin
         if (!nRST) begin
            checkOutput("RST_O_VALID", O_VALID, 0);
            checkOutput("RST_O_TAG", O_TAG, 0);
            checkOutput("RST_O_MASK", O_MASK, 0);
            checkOutput("RST_O_DATA", {O_X, O_Y, O_Z, O_W}, 0);
            checkOutput("RST_OVERRUN", OVERRUN, 0);
            sb.delete();
            capQ.delete();
            tbCredit  = 0;
            tbOverrun = 1'b0;
         end else begin
            expValid = (sb.size() > 0) && (sb[0].readyCyc <= cyc);
            checkOutput("ISSUE_READY", ISSUE_READY, tbCredit < DEPTH);
            checkOutput("OVERRUN", OVERRUN, tbOverrun);
            checkOutput("O_VALID", O_VALID, expValid);
            if (expValid) begin
               checkOutput("O_TAG", O_TAG, sb[0].tag);
               checkOutput("O_MASK", O_MASK, sb[0].mask);
               checkOutput("O_X", O_X, sb[0].x);
               checkOutput("O_Y", O_Y, sb[0].y);
               checkOutput("O_Z", O_Z, sb[0].z);
               checkOutput("O_W", O_W, sb[0].w);
            end
            accept = !ISSUE_nEN && (tbCredit < DEPTH);
            hs     = expValid && O_READY;
            if (!ISSUE_nEN && !(tbCredit < DEPTH)) tbOverrun = 1'b1;
            if (accept) begin
               e.tag  = ISSUE_TAG;
               e.mask = ISSUE_MASK;
               e.x = ISSUE_MASK[3] ? issueX : 32'h0;
               e.y = ISSUE_MASK[2] ? issueY : 32'h0;
               e.z = ISSUE_MASK[1] ? issueZ : 32'h0;
               e.w = ISSUE_MASK[0] ? issueW : 32'h0;
               e.readyCyc = cyc + OUT_LAT;
               sb.push_back(e);
               capQ.push_back('{cyc + LATENCY, issueX, issueY, issueZ, issueW});
            end
            if (hs) void'(sb.pop_front());
            tbCredit = tbCredit + (accept ? 1 : 0) - (hs ? 1 : 0);
         end
      end
   end

   initial begin
      nRST = 1'b0;
      ISSUE_nEN = 1'b1; ISSUE_TAG = '0; ISSUE_MASK = '0;
      issueX = '0; issueY = '0; issueZ = '0; issueW = '0;
      O_READY = 1'b0;
      IX = '0; IY = '0; IZ = '0; IW = '0;
      started = 1'b1;
      $display("[TB] start, LATENCY=%0d DEPTH=%0d output latency=%0d", LATENCY, DEPTH, OUT_LAT);

      idle(3);
      @(negedge CLK); nRST = 1'b1;

      // Single full-mask issue with known lane values.
      O_READY = 1'b1;
      applyStimulus(1'b1, 4'd3, 4'b1111, 32'd1, 32'd2, 32'd3, 32'd4);
      idle(6);

      // Lane masking.
      applyStimulus(1'b1, 4'd7, 4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle(6);

      // Back-pressure: six back-to-back issues, only four fit.
      O_READY = 1'b0;
      for (int t = 0; t < 6; t++)
         applyStimulus(1'b1, TAG_W'(t), 4'b1111, 32'h100 + 32'(t), 32'h200 + 32'(t), 32'h300 + 32'(t), 32'h400 + 32'(t));
      idle(4);
      O_READY = 1'b1;
      idle(8);

      // Full throughput with the consumer always ready.
      for (int t = 0; t < 16; t++)
         applyStimulus(1'b1, TAG_W'(t), 4'(t), 32'h1000 + 32'(t), 32'h2000 + 32'(t), 32'h3000 + 32'(t), 32'h4000 + 32'(t));
      idle(8);

      // Random mix of issue and back-pressure.
      for (int t = 0; t < 60; t++) begin
         applyStimulus($urandom_range(0, 3) != 0, TAG_W'(t), 4'($urandom_range(0, 15)),
                       $urandom, $urandom, $urandom, $urandom);
         O_READY = ($urandom_range(0, 2) != 0);
      end
      O_READY = 1'b1;
      idle(10);

      // Reset with two results buffered and two still in the pipe.
      O_READY = 1'b0;
      for (int t = 0; t < 4; t++)
         applyStimulus(1'b1, TAG_W'(8 + t), 4'b1111, 32'hA0 + 32'(t), 32'hB0 + 32'(t), 32'hC0 + 32'(t), 32'hD0 + 32'(t));
      applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);
      nRST = 1'b0;
      @(negedge CLK); nRST = 1'b1;
      O_READY = 1'b1;
      ISSUE_nEN = 1'b1;
      idle(10);

      // Normal operation resumes after reset.
      applyStimulus(1'b1, 4'd9, 4'b1010, 32'h11, 32'h22, 32'h33, 32'h44);
      idle(6);

      checkOutput("SB_DRAINED", 128'(sb.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/mtsp_scs_writeback.md
MTSP_SCS_WRITEBACK -- requirements
Module: mtsp_scs_writeback

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from an accepted issue (ISSUE_nEN low) to its result appearing on IX..IW; legal range 1..8.
REQ-002 SHALL have parameter DEPTH, default 4, meaning result FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameter TAG_W, default 4, meaning width of the instruction tag carried with each result.
REQ-004 CLK  input  1  main clock; all state is updated on the rising edge.
REQ-005 nRST  input  1  reset; one clock, and reset is asynchronous and active-low.
REQ-006 ISSUE_nEN  input  1  active-low issue strobe; an exact copy of the nEN driven to the SCs primitive.
REQ-007 ISSUE_TAG  input  TAG_W  tag of the issued instruction.
REQ-008 ISSUE_MASK  input  4  lane enables {X,Y,Z,W}, equal to bit 2 of each OP nibble.
REQ-009 ISSUE_READY  output  1  high when an issue may be accepted this cycle.
REQ-010 IX, IY, IZ, IW  input  32 each  primitive results (OX..OW of the SCs primitive).
REQ-011 O_VALID  output  1  result available.
REQ-012 O_READY  input  1  consumer accepts the result.
REQ-013 O_TAG  output  TAG_W  tag of the presented result.
REQ-014 O_MASK  output  4  lane mask of the presented result.
REQ-015 O_X, O_Y, O_Z, O_W  output  32 each  result data.
REQ-016 OVERRUN  output  1  sticky error flag: an issue was attempted while ISSUE_READY was low.

Function
REQ-017 An issue SHALL be accepted when ISSUE_nEN=0 and ISSUE_READY=1; an accepted issue pushes {TAG,MASK} into a LATENCY-stage valid/tag shift pipe.
REQ-018 When a pipe entry exits after exactly LATENCY cycles, the block SHALL capture IX..IW in that cycle and write {tag, mask, data} into the FIFO.
REQ-019 Before storage, the captured data SHALL be zero in each lane whose mask bit is 0.
REQ-020 Credit count = in-flight entries + FIFO occupancy; ISSUE_READY SHALL be 1 exactly when credit count < DEPTH, so the FIFO can never overflow.
REQ-021 Credit count SHALL increment on an accepted issue and decrement on an output handshake (O_VALID & O_READY); when both occur in the same cycle, it SHALL stay unchanged.
REQ-022 O_VALID SHALL be 1 when the FIFO is non-empty; O_TAG, O_MASK and O_X..O_W SHALL present the head entry; the head SHALL pop only on a handshake.
REQ-023 While O_VALID=1 and O_READY=0, all O_* outputs SHALL hold stable.
REQ-024 Results SHALL leave in issue order; FIFO pointers SHALL wrap modulo DEPTH.
REQ-025 A write and a pop in the same cycle SHALL leave occupancy unchanged, including when the FIFO is full.
REQ-026 ISSUE_nEN=0 while ISSUE_READY=0 SHALL be ignored (no pipe entry created) and SHALL set OVERRUN; OVERRUN clears only on reset.
REQ-027 Base latency, without bypass, SHALL be LATENCY+1 cycles from issue to O_VALID.

Reset
REQ-028 On nRST low: pipe valids, FIFO pointers, credit count and OVERRUN SHALL clear to 0; O_VALID=0; O_TAG, O_MASK and O_X..O_W SHALL be 0; ISSUE_READY=1 one cycle after release.
REQ-029 Reset mid-operation SHALL discard all in-flight and buffered results; no stale result SHALL appear after release.

Configuration
REQ-030 Macro MTSP_SCS_WB_BYPASS_EN: when defined and the FIFO is empty, a result exiting the pipe SHALL drive O_* combinationally in its capture cycle with O_VALID=1.
REQ-031 Under MTSP_SCS_WB_BYPASS_EN, if O_READY=1 in that capture cycle, the result SHALL NOT be written to the FIFO; latency becomes LATENCY.
REQ-032 Without MTSP_SCS_WB_BYPASS_EN, every result SHALL pass through the FIFO, with latency LATENCY+1.

Structure
REQ-033 The shared package mtsp_scs_pkg SHALL hold the lane-count constant (4), the word width (32), and typedef scs_result_t {tag, mask[3:0], data[4][31:0]}.
REQ-034 The FIFO SHALL be the sub-module mtsp_scs_wb_fifo (parameters DEPTH and payload type; ports push, pop, full, empty, head).

Verification
REQ-035 Single issue at defaults: TAG=3, MASK=4'b1111, IX..IW=1,2,3,4 at the capture cycle, O_READY=1 -> O_VALID at cycle +3 with O_TAG=3 and O_X..O_W=1,2,3,4.
REQ-036 Lane masking: MASK=4'b0101, inputs all 32'hFFFFFFFF -> O_X=0, O_Y=FFFFFFFF, O_Z=0, O_W=FFFFFFFF.
REQ-037 Back-pressure: O_READY=0, issue every cycle with tags 0..5 -> ISSUE_READY falls after 4 accepts, OVERRUN=1, and when O_READY=1 the tags drain as 0,1,2,3 only.
REQ-038 Full throughput: O_READY=1, issues every cycle with tags 0..15 -> no ISSUE_READY drop and in-order output at one per cycle.
REQ-039 Reset mid-flight: 2 issued, 2 buffered, nRST pulsed -> O_VALID=0, credit count=0, and no output for 10 cycles afterwards.
REQ-040 Bypass build: single issue with the FIFO empty -> O_VALID at cycle +2; without the macro -> at cycle +3.
